// File: rtl/enet_bus_arbiter.sv
// ---------------------------------------------------------------------------
// enet_bus_arbiter
//
// Shares the single Ethernet-controller command port among N clients (e.g.
// interrupt detector, TX engine, RX engine, init/config sequencer) using a
// req/grant handshake with round-robin priority. The granted client's command
// fields are muxed onto the controller-driver interface. Read data is
// broadcast back to every client.
//
// Handshake: a client raises req_in[i] and holds it for as long as it needs
// the port. grant_out[i] goes high one cycle after the request is sampled.
// The client may drive start_in[i] and its command fields only while
// grant_out[i] is high. Dropping req_in[i] releases the port, but the grant
// (and the mux) stays in place until enet_rdy_in reports the driver idle.
// After a release, grant_out is zero for at least one cycle before the next
// owner is granted.
//
// Ports:
//   Clock, Reset        system clock; synchronous, active-high reset
//   req_in[N]           per-client bus request
//   grant_out[N]        registered one-hot grant
//   addr_in/dataw_in/delay_in/start_in/type_in
//                       packed per-client command fields (client i at slice i)
//   enet_rdy_in         controller driver idle/ready
//   enet_datar_in       read data from the driver
//   datar_out           enet_datar_in broadcast to all clients
//   enet_*_out          command fields of the current owner; 0 with no grant
//   busy_out            any grant asserted
//   owner_out           index of the granted client; 0 when none
//   timeout_err_out     sticky watchdog flag
//
// Optional feature, macro ARB_WATCHDOG_EN: a 16-bit hold counter revokes a
// grant held for TIMEOUT cycles and sets timeout_err_out until Reset. When
// the macro is undefined there is no counter and timeout_err_out is 0.
//
// The FSM state register state_q is visible hierarchically for debug.
// ---------------------------------------------------------------------------
module enet_bus_arbiter #(
  parameter int N       = 4,
  parameter int IDW     = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [N-1:0]      req_in,
  output logic [N-1:0]      grant_out,
  input  logic [8*N-1:0]    addr_in,
  input  logic [16*N-1:0]   dataw_in,
  input  logic [3*N-1:0]    delay_in,
  input  logic [N-1:0]      start_in,
  input  logic [2*N-1:0]    type_in,
  input  logic              enet_rdy_in,
  input  logic [15:0]       enet_datar_in,
  output logic [15:0]       datar_out,
  output logic [7:0]        enet_addr_out,
  output logic [15:0]       enet_dataw_out,
  output logic [2:0]        enet_delay_out,
  output logic              enet_start_out,
  output logic [1:0]        enet_type_out,
  output logic              busy_out,
  output logic [IDW-1:0]    owner_out,
  output logic              timeout_err_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  // Round-robin search: first requester at or above rr_ptr, with wrap.
  logic found;
  int   pick_idx;

  always_comb begin
    found    = 1'b0;
    pick_idx = 0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % N;
      if (!found && req_in[idx]) begin
        found    = 1'b1;
        pick_idx = idx;
      end
    end
  end

`ifdef ARB_WATCHDOG_EN
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic        timeout_err_q, timeout_err_d;
`else
  // TIMEOUT only matters with the watchdog built in.
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
`ifdef ARB_WATCHDOG_EN
    hold_cnt_d    = hold_cnt_q;
    timeout_err_d = timeout_err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d  = (N)'(1) << pick_idx;
          // The new owner drops to lowest priority for the next search.
          rr_ptr_d = IDW'((pick_idx + 1) % N);
          state_d  = ST_BUSY;
`ifdef ARB_WATCHDOG_EN
          hold_cnt_d = 16'd0;
`endif
        end
      end
      ST_BUSY: begin
        if ((req_in & grant_q) == '0) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Keep the owner until the driver finishes any command in flight.
        if (enet_rdy_in) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase

`ifdef ARB_WATCHDOG_EN
    if (state_q == ST_BUSY || state_q == ST_DRAIN) begin
      // Counter reads k after k held edges, so the grant is visible for
      // exactly TIMEOUT cycles before being revoked.
      if (hold_cnt_q == 16'(TIMEOUT - 1)) begin
        grant_d       = '0;
        state_d       = ST_IDLE;
        timeout_err_d = 1'b1;
      end else begin
        hold_cnt_d = hold_cnt_q + 16'd1;
      end
    end
`endif
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef ARB_WATCHDOG_EN
  always_ff @(posedge Clock) begin
    if (Reset) begin
      hold_cnt_q    <= 16'd0;
      timeout_err_q <= 1'b0;
    end else begin
      hold_cnt_q    <= hold_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign timeout_err_out = timeout_err_q;
`else
  assign timeout_err_out = 1'b0;
`endif

  // AND-OR mux driven by the one-hot grant: all fields read 0 with no grant.
  always_comb begin
    owner_out      = '0;
    enet_addr_out  = '0;
    enet_dataw_out = '0;
    enet_delay_out = '0;
    enet_start_out = 1'b0;
    enet_type_out  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) begin
        owner_out      = owner_out | IDW'(i);
        enet_addr_out  = enet_addr_out  | addr_in[8*i +: 8];
        enet_dataw_out = enet_dataw_out | dataw_in[16*i +: 16];
        enet_delay_out = enet_delay_out | delay_in[3*i +: 3];
        enet_start_out = enet_start_out | start_in[i];
        enet_type_out  = enet_type_out  | type_in[2*i +: 2];
      end
    end
  end

  assign grant_out = grant_q;
  assign busy_out  = |grant_q;
  assign datar_out = enet_datar_in;

endmodule

// File: tb/tb_enet_bus_arbiter.sv
module tb_enet_bus_arbiter;

  localparam int N   = 4;
  localparam int IDW = 3;

  // ---------------- clock / reset ----------------
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  logic [N-1:0]    req_in = '0;
  logic [N-1:0]    grant_out;
  logic [8*N-1:0]  addr_in = '0;
  logic [16*N-1:0] dataw_in = '0;
  logic [3*N-1:0]  delay_in = '0;
  logic [N-1:0]    start_in = '0;
  logic [2*N-1:0]  type_in = '0;
  logic            enet_rdy_in = 1'b1;
  logic [15:0]     enet_datar_in = '0;
  logic [15:0]     datar_out;
  logic [7:0]      enet_addr_out;
  logic [15:0]     enet_dataw_out;
  logic [2:0]      enet_delay_out;
  logic            enet_start_out;
  logic [1:0]      enet_type_out;
  logic            busy_out;
  logic [IDW-1:0]  owner_out;
  logic            timeout_err_out;

  int checks = 0;
  int errors = 0;

  enet_bus_arbiter #(.N(N), .IDW(IDW), .TIMEOUT(20)) dut (
    .Clock(Clock), .Reset(Reset), .req_in(req_in), .grant_out(grant_out),
    .addr_in(addr_in), .dataw_in(dataw_in), .delay_in(delay_in),
    .start_in(start_in), .type_in(type_in), .enet_rdy_in(enet_rdy_in),
    .enet_datar_in(enet_datar_in), .datar_out(datar_out),
    .enet_addr_out(enet_addr_out), .enet_dataw_out(enet_dataw_out),
    .enet_delay_out(enet_delay_out), .enet_start_out(enet_start_out),
    .enet_type_out(enet_type_out), .busy_out(busy_out),
    .owner_out(owner_out), .timeout_err_out(timeout_err_out)
  );

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic apply_reset();
    Reset    = 1'b1;
    req_in   = '0;
    start_in = '0;
    step();
    step();
    Reset = 1'b0;
  endtask

  task automatic set_client(input int i, input logic [7:0] a, input logic [15:0] d,
                            input logic [2:0] dl, input logic [1:0] t);
    addr_in[8*i +: 8]   = a;
    dataw_in[16*i +: 16] = d;
    delay_in[3*i +: 3]  = dl;
    type_in[2*i +: 2]   = t;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_client(0, 8'h11, 16'h1111, 3'd1, 2'd1);
    set_client(1, 8'hFE, 16'hBEEF, 3'd5, 2'd0);
    set_client(2, 8'hA5, 16'h5A5A, 3'd6, 2'd2);
    set_client(3, 8'h3C, 16'hC3C3, 3'd7, 2'd3);
    start_in = 4'b1111;
    apply_reset();
    checks++; if (grant_out !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b, expected 0000", grant_out); end
    checks++; if (owner_out !== 3'd0 || busy_out !== 1'b0) begin errors++; $display("FAIL reset_owner_busy: got owner=%0d busy=%b, expected 0/0", owner_out, busy_out); end
    checks++; if (timeout_err_out !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, expected 0", timeout_err_out); end
    checks++;
    if ({enet_addr_out, enet_dataw_out, enet_delay_out, enet_start_out, enet_type_out} !== 30'd0) begin
      errors++; $display("FAIL reset_enet_zero: got addr=%h dataw=%h delay=%0d start=%b type=%0d, expected all 0",
                         enet_addr_out, enet_dataw_out, enet_delay_out, enet_start_out, enet_type_out);
    end
    start_in = '0;
  endtask

  task automatic test_single_request();
    apply_reset();
    enet_rdy_in = 1'b1;
    for (int c = 0; c < 3; c++) step();
    req_in = 4'b0010;
    checks++; if (grant_out !== 4'b0000) begin errors++; $display("FAIL single_pre_grant: got %b, expected 0000", grant_out); end
    step();
    checks++; if (grant_out !== 4'b0010) begin errors++; $display("FAIL single_grant: got %b, expected 0010", grant_out); end
    checks++; if (owner_out !== 3'd1 || busy_out !== 1'b1) begin errors++; $display("FAIL single_owner: got owner=%0d busy=%b, expected 1/1", owner_out, busy_out); end
    start_in = 4'b0010;
    #1;
    checks++;
    if (enet_addr_out !== 8'hFE || enet_type_out !== 2'd0 || enet_start_out !== 1'b1 ||
        enet_dataw_out !== 16'hBEEF || enet_delay_out !== 3'd5) begin
      errors++; $display("FAIL single_mux: got addr=%h type=%0d start=%b dataw=%h delay=%0d, expected FE/0/1/BEEF/5",
                         enet_addr_out, enet_type_out, enet_start_out, enet_dataw_out, enet_delay_out);
    end
    step();
    start_in = '0;
    req_in = '0;
    step();
    checks++; if (grant_out !== 4'b0010) begin errors++; $display("FAIL single_drain_hold: got %b, expected 0010", grant_out); end
    step();
    checks++; if (grant_out !== 4'b0000 || busy_out !== 1'b0) begin errors++; $display("FAIL single_release: got %b busy=%b, expected 0000/0", grant_out, busy_out); end
  endtask

  task automatic test_contention();
    logic [N-1:0] exp_g;
    int idle;
    int prev;
    apply_reset();
    enet_rdy_in = 1'b1;
    req_in = 4'b1111;
    step();
    checks++; if (grant_out !== 4'b0001) begin errors++; $display("FAIL cont_first: got %b, expected 0001", grant_out); end
    for (int k = 1; k <= 4; k++) begin
      prev = (k - 1) % 4;
      exp_g = 4'b0001 << (k % 4);
      step();
      step();
      req_in[prev] = 1'b0;
      step();
      checks++; if (grant_out !== (4'b0001 << prev)) begin errors++; $display("FAIL cont_drain_%0d: got %b, expected %b", k, grant_out, 4'b0001 << prev); end
      req_in[prev] = 1'b1;  // re-request goes to the back of the line
      idle = 0;
      for (int w = 0; w < 8; w++) begin
        step();
        if (grant_out === 4'b0000) idle++;
        else break;
      end
      checks++; if (grant_out !== exp_g) begin errors++; $display("FAIL cont_order_%0d: got %b, expected %b", k, grant_out, exp_g); end
      checks++; if (idle !== 1) begin errors++; $display("FAIL cont_gap_%0d: got %0d idle cycles, expected 1", k, idle); end
    end
    req_in = '0;
  endtask

  task automatic test_drain_hold();
    apply_reset();
    enet_rdy_in = 1'b0;
    req_in = 4'b0100;
    step();
    checks++; if (grant_out !== 4'b0100) begin errors++; $display("FAIL drain_grant: got %b, expected 0100", grant_out); end
    req_in = '0;
    step();
    for (int c = 0; c < 7; c++) begin
      step();
      checks++; if (grant_out !== 4'b0100) begin errors++; $display("FAIL drain_hold_%0d: got %b, expected 0100", c, grant_out); end
    end
    enet_rdy_in = 1'b1;
    step();
    checks++; if (grant_out !== 4'b0000 || enet_addr_out !== 8'h00) begin errors++; $display("FAIL drain_release: got %b addr=%h, expected 0000/00", grant_out, enet_addr_out); end
  endtask

  task automatic test_start_isolation();
    apply_reset();
    enet_rdy_in = 1'b1;
    set_client(0, 8'h10, 16'h1111, 3'd1, 2'd1);
    req_in = 4'b0100;
    step();
    checks++; if (owner_out !== 3'd2) begin errors++; $display("FAIL iso_owner: got %0d, expected 2", owner_out); end
    start_in = 4'b0001;
    #1;
    checks++; if (enet_start_out !== 1'b0) begin errors++; $display("FAIL iso_start: got %b, expected 0", enet_start_out); end
    checks++;
    if (enet_addr_out !== 8'hA5 || enet_dataw_out !== 16'h5A5A || enet_delay_out !== 3'd6 || enet_type_out !== 2'd2) begin
      errors++; $display("FAIL iso_fields: got addr=%h dataw=%h delay=%0d type=%0d, expected A5/5A5A/6/2",
                         enet_addr_out, enet_dataw_out, enet_delay_out, enet_type_out);
    end
    start_in = 4'b0101;
    enet_datar_in = 16'h1234;
    #1;
    checks++; if (enet_start_out !== 1'b1) begin errors++; $display("FAIL iso_owner_start: got %b, expected 1", enet_start_out); end
    checks++; if (datar_out !== 16'h1234) begin errors++; $display("FAIL datar_broadcast: got %h, expected 1234", datar_out); end
    start_in = '0;
    req_in = '0;
    step();
    step();
  endtask

  task automatic test_rerequest();
    apply_reset();
    enet_rdy_in = 1'b1;
    req_in = 4'b0010;
    step();
    req_in = 4'b0000;
    step();                 // BUSY -> DRAIN
    req_in = 4'b0011;       // owner re-raises, client0 also waiting
    step();                 // DRAIN releases
    checks++; if (grant_out !== 4'b0000) begin errors++; $display("FAIL rereq_gap: got %b, expected 0000", grant_out); end
    step();
    checks++; if (grant_out !== 4'b0001) begin errors++; $display("FAIL rereq_wrap: got %b, expected 0001", grant_out); end
    req_in = '0;
  endtask

  task automatic test_reset_mid_busy();
    apply_reset();
    req_in = 4'b1000;
    step();
    checks++; if (grant_out !== 4'b1000 || owner_out !== 3'd3) begin errors++; $display("FAIL midrst_grant: got %b owner=%0d, expected 1000/3", grant_out, owner_out); end
    Reset = 1'b1;
    step();
    checks++; if (grant_out !== 4'b0000 || owner_out !== 3'd0 || busy_out !== 1'b0) begin errors++; $display("FAIL midrst_drop: got %b owner=%0d busy=%b, expected 0000/0/0", grant_out, owner_out, busy_out); end
    Reset = 1'b0;
    req_in = 4'b1111;
    step();
    checks++; if (grant_out !== 4'b0001) begin errors++; $display("FAIL midrst_rr: got %b, expected 0001", grant_out); end
    req_in = '0;
  endtask

  task automatic test_watchdog();
`ifdef ARB_WATCHDOG_EN
    int hi;
    apply_reset();
    enet_rdy_in = 1'b1;
    req_in = 4'b0110;
    step();
    hi = 0;
    for (int w = 0; w < 40; w++) begin
      if (grant_out === 4'b0010) hi++;
      else break;
      step();
    end
    checks++; if (hi !== 20) begin errors++; $display("FAIL wd_hold: got %0d cycles, expected 20", hi); end
    checks++; if (grant_out !== 4'b0000 || timeout_err_out !== 1'b1) begin errors++; $display("FAIL wd_revoke: got %b err=%b, expected 0000/1", grant_out, timeout_err_out); end
    step();
    checks++; if (grant_out !== 4'b0100) begin errors++; $display("FAIL wd_next: got %b, expected 0100", grant_out); end
    req_in = '0;
`else
    apply_reset();
    enet_rdy_in = 1'b1;
    req_in = 4'b0010;
    for (int c = 0; c < 30; c++) step();
    checks++; if (grant_out !== 4'b0010 || timeout_err_out !== 1'b0) begin errors++; $display("FAIL no_wd_hold: got %b err=%b, expected 0010/0", grant_out, timeout_err_out); end
    req_in = '0;
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_request();
    test_contention();
    test_drain_hold();
    test_start_isolation();
    test_rerequest();
    test_reset_mid_busy();
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
